// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified I/D memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_DM   = 2'd2
  } resp_state_e;

  localparam int MAX_STARVE_DEF = 4;
  localparam int BE_W = 4;
  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

  // Loads always read the whole word; only stores honour the requester's lanes.
  function automatic logic [BE_W-1:0] data_be(input logic we, input logic [BE_W-1:0] be);
    return we ? be : BE_WORD;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side bus bundle for mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  import mem_port_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              stall_if;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [BE_W-1:0]   dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, stall_if, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, stall_if, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive denied fetch cycles; at_max flips priority to fetch.
module starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [CNT_W-1:0] cnt_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else if (clr) begin
      cnt_p1 <= '0;
    end else if (inc && !at_max) begin
      cnt_p1 <= cnt_p1 + CNT_W'(1);
    end
  end

  assign at_max = (cnt_p1 == CNT_W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between fetch and data access,
// steering the one-cycle-late read data back to whichever side owned the port.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = MAX_STARVE_DEF
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  logic              if_gnt_c;
  logic              dm_gnt_c;
  logic              at_max;
  logic              starve_inc;
  logic              starve_clr;
  logic              mem_en_c;
  logic              mem_we_c;
  logic [BE_W-1:0]   mem_be_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  resp_state_e       state_p1;
  resp_state_e       state_nxt;
  logic              if_rvalid_c;
  logic              dm_rvalid_c;
  logic [DATA_W-1:0] if_rdata_p1;
  logic [DATA_W-1:0] dm_rdata_p1;
  logic              unused_addr_bits;

  // Grants are forced low while reset is asserted so nothing reaches the memory.
  always_comb begin
    if_gnt_c = rst_n & bus.if_req & (~bus.dm_req | at_max);
    dm_gnt_c = rst_n & bus.dm_req & ~if_gnt_c;
  end

  assign starve_inc = bus.if_req & ~if_gnt_c;
  assign starve_clr = if_gnt_c | ~bus.if_req;

  starve_counter #(.MAX(MAX_STARVE)) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (at_max)
  );

  // Byte offsets are dropped at the port; sub-word extraction happens downstream.
  assign unused_addr_bits = ^{bus.if_addr[1:0], bus.dm_addr[1:0]};

  always_comb begin
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_be_c    = '0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    if (if_gnt_c) begin
      mem_en_c   = 1'b1;
      mem_be_c   = BE_WORD;
      mem_addr_c = {bus.if_addr[ADDR_W-1:2], 2'b00};
    end else if (dm_gnt_c) begin
      mem_en_c    = 1'b1;
      mem_we_c    = bus.dm_we;
      mem_be_c    = data_be(bus.dm_we, bus.dm_be);
      mem_addr_c  = {bus.dm_addr[ADDR_W-1:2], 2'b00};
      mem_wdata_c = bus.dm_wdata;
    end
  end

  // ---- stage p0 -> p1: response ownership for next cycle's read data ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= RESP_IDLE;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = RESP_IDLE;
    if_rvalid_c = 1'b0;
    dm_rvalid_c = 1'b0;
    if (if_gnt_c) begin
      state_nxt = RESP_IF;
    end else if (dm_gnt_c && !bus.dm_we) begin
      state_nxt = RESP_DM;
    end
    case (state_p1)
      RESP_IF: if_rvalid_c = 1'b1;
      RESP_DM: dm_rvalid_c = 1'b1;
      default: ;
    endcase
  end

  // ---- stage p1: capture returned word so the non-owner keeps its last value ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_p1 <= '0;
      dm_rdata_p1 <= '0;
    end else begin
      if (if_rvalid_c) if_rdata_p1 <= bus.mem_rdata;
      if (dm_rvalid_c) dm_rdata_p1 <= bus.mem_rdata;
    end
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.dm_gnt    = dm_gnt_c;
  assign bus.stall_if  = bus.if_req & ~if_gnt_c;
  assign bus.if_rvalid = if_rvalid_c;
  assign bus.dm_rvalid = dm_rvalid_c;
  assign bus.if_rdata  = if_rvalid_c ? bus.mem_rdata : if_rdata_p1;
  assign bus.dm_rdata  = dm_rvalid_c ? bus.mem_rdata : dm_rdata_p1;
  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_be    = mem_be_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, reset corner case,
// then randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int MAXS   = 4;
  localparam int WORDS  = 1 << (ADDR_W - 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STARVE(MAXS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous single-port memory driven only by the DUT's memory port.
  logic [31:0] mem_arr [WORDS];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem_arr[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= mem_arr[bus.mem_addr[7:2]];
      end
    end
  end

  // Reference model state: expected memory contents, starvation count, pending responses.
  logic [31:0] ref_mem [WORDS];
  int          m_starve;
  logic        m_if_v, m_dm_v;
  logic [31:0] m_if_d, m_dm_d;

  logic        c_ir, c_dr, c_dwe;
  logic [7:0]  c_ia, c_da;
  logic [3:0]  c_dbe;
  logic [31:0] c_dwd;
  logic        x_if, x_dm;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic ir; logic [7:0] ia; logic dr; logic dwe; logic [3:0] dbe; logic [7:0] da; logic [31:0] dwd;
    logic e_if; logic e_dm; logic e_stall; logic [7:0] e_addr; logic e_we; logic [3:0] e_be;
    logic e_if_rv; logic [31:0] e_if_rd; logic e_dm_rv; logic [31:0] e_dm_rd;
  } vec_t;
  vec_t tbl [$];

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    w = 32'h1000_0000 | (32'(i) << 8) | 32'(i);
    return (i == 0) ? 32'h0010_0093 : w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    m_if_v = 1'b0;
    m_dm_v = 1'b0;
    m_if_d = '0;
    m_dm_d = '0;
  endtask

  task automatic drive_check(input logic ir, input logic [7:0] ia, input logic dr, input logic dwe,
                             input logic [3:0] dbe, input logic [7:0] da, input logic [31:0] dwd);
    logic        e_en, e_we;
    logic [3:0]  e_be;
    logic [7:0]  e_addr;
    logic [31:0] e_wd;
    bus.if_req = ir; bus.if_addr = ia; bus.dm_req = dr; bus.dm_we = dwe;
    bus.dm_be = dbe; bus.dm_addr = da; bus.dm_wdata = dwd;
    c_ir = ir; c_ia = ia; c_dr = dr; c_dwe = dwe; c_dbe = dbe; c_da = da; c_dwd = dwd;
    #2;
    x_if = rst_n && ir && (!dr || m_starve >= MAXS);
    x_dm = rst_n && dr && !x_if;
    e_en = x_if || x_dm;
    e_we = x_dm && dwe;
    e_be = x_if ? 4'hF : (x_dm ? (dwe ? dbe : 4'hF) : 4'h0);
    e_addr = x_if ? (ia & 8'hFC) : (x_dm ? (da & 8'hFC) : 8'h00);
    e_wd = x_dm ? dwd : 32'h0;
    chk("if_gnt", bus.if_gnt, x_if);
    chk("dm_gnt", bus.dm_gnt, x_dm);
    chk("stall_if", bus.stall_if, ir && !x_if);
    chk("mem_en", bus.mem_en, e_en);
    chk("mem_we", bus.mem_we, e_we);
    chk("mem_be", bus.mem_be, e_be);
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_wdata", bus.mem_wdata, e_wd);
    chk("if_rvalid", bus.if_rvalid, m_if_v);
    chk("dm_rvalid", bus.dm_rvalid, m_dm_v);
    chk("if_rdata", bus.if_rdata, m_if_d);
    chk("dm_rdata", bus.dm_rdata, m_dm_d);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst_n) begin
      m_if_v = x_if;
      m_dm_v = x_dm && !c_dwe;
      if (m_if_v) m_if_d = ref_mem[c_ia[7:2]];
      if (m_dm_v) m_dm_d = ref_mem[c_da[7:2]];
      if (x_dm && c_dwe)
        for (int b = 0; b < 4; b++)
          if (c_dbe[b]) ref_mem[c_da[7:2]][8*b +: 8] = c_dwd[8*b +: 8];
      if (x_if || !c_ir) m_starve = 0;
      else m_starve = (m_starve + 1 > MAXS) ? MAXS : m_starve + 1;
    end
    @(negedge clk);
  endtask

  task automatic addv(input logic ir, input logic [7:0] ia, input logic dr, input logic dwe,
                      input logic [3:0] dbe, input logic [7:0] da, input logic [31:0] dwd,
                      input logic e_if, input logic e_dm, input logic e_stall, input logic [7:0] e_addr,
                      input logic e_we, input logic [3:0] e_be, input logic e_if_rv, input logic [31:0] e_if_rd,
                      input logic e_dm_rv, input logic [31:0] e_dm_rd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.dbe = dbe; v.da = da; v.dwd = dwd;
    v.e_if = e_if; v.e_dm = e_dm; v.e_stall = e_stall; v.e_addr = e_addr; v.e_we = e_we; v.e_be = e_be;
    v.e_if_rv = e_if_rv; v.e_if_rd = e_if_rd; v.e_dm_rv = e_dm_rv; v.e_dm_rd = e_dm_rd;
    tbl.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem_arr[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    bus.mem_rdata = '0;
    model_reset();

    // Reset state: both requesting, nothing granted, registered outputs zero.
    drive_check(1'b1, 8'h00, 1'b1, 1'b0, 4'hF, 8'h10, 32'h0);
    chk("reset_if_gnt", bus.if_gnt, 1'b0);
    chk("reset_dm_rvalid", bus.dm_rvalid, 1'b0);
    advance();
    rst_n = 1'b1;

    // Single fetch, then fetch-vs-load collision.
    addv(1, 8'h00, 0, 0, 4'h0, 8'h00, 0,   1, 0, 0, 8'h00, 0, 4'hF, 0, 0, 0, 0);
    addv(0, 8'h00, 0, 0, 4'h0, 8'h00, 0,   0, 0, 0, 8'h00, 0, 4'h0, 1, 32'h0010_0093, 0, 0);
    addv(1, 8'h04, 1, 0, 4'hF, 8'h10, 0,   0, 1, 1, 8'h10, 0, 4'hF, 0, 0, 0, 0);
    addv(1, 8'h04, 0, 0, 4'h0, 8'h00, 0,   1, 0, 0, 8'h04, 0, 4'hF, 0, 0, 1, 32'h1000_0404);
    addv(0, 8'h00, 0, 0, 4'h0, 8'h00, 0,   0, 0, 0, 8'h00, 0, 4'h0, 1, 32'h1000_0101, 0, 0);
    // Starvation: DM wins four times, IF on the fifth, DM again on the sixth.
    addv(1, 8'h08, 1, 0, 4'hF, 8'h20, 0,   0, 1, 1, 8'h20, 0, 4'hF, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      addv(1, 8'h08, 1, 0, 4'hF, 8'h20, 0, 0, 1, 1, 8'h20, 0, 4'hF, 0, 0, 1, 32'h1000_0808);
    addv(1, 8'h08, 1, 0, 4'hF, 8'h20, 0,   1, 0, 0, 8'h08, 0, 4'hF, 0, 0, 1, 32'h1000_0808);
    addv(1, 8'h08, 1, 0, 4'hF, 8'h20, 0,   0, 1, 1, 8'h20, 0, 4'hF, 1, 32'h1000_0202, 0, 0);
    addv(0, 8'h00, 0, 0, 4'h0, 8'h00, 0,   0, 0, 0, 8'h00, 0, 4'h0, 0, 0, 1, 32'h1000_0808);
    // Misaligned partial store, no response afterwards.
    addv(0, 8'h00, 1, 1, 4'hC, 8'h62, 32'h0005_0000, 0, 1, 0, 8'h60, 1, 4'hC, 0, 0, 0, 0);
    addv(0, 8'h00, 0, 0, 4'h0, 8'h00, 0,   0, 0, 0, 8'h00, 0, 4'h0, 0, 0, 0, 0);
    // Back-to-back fetches.
    addv(1, 8'h00, 0, 0, 4'h0, 8'h00, 0,   1, 0, 0, 8'h00, 0, 4'hF, 0, 0, 0, 0);
    addv(1, 8'h04, 0, 0, 4'h0, 8'h00, 0,   1, 0, 0, 8'h04, 0, 4'hF, 1, 32'h0010_0093, 0, 0);
    addv(1, 8'h08, 0, 0, 4'h0, 8'h00, 0,   1, 0, 0, 8'h08, 0, 4'hF, 1, 32'h1000_0101, 0, 0);
    addv(0, 8'h00, 0, 0, 4'h0, 8'h00, 0,   0, 0, 0, 8'h00, 0, 4'h0, 1, 32'h1000_0202, 0, 0);
    // Read back the partially stored word.
    addv(0, 8'h00, 1, 0, 4'hF, 8'h60, 0,   0, 1, 0, 8'h60, 0, 4'hF, 0, 0, 0, 0);
    addv(0, 8'h00, 0, 0, 4'h0, 8'h00, 0,   0, 0, 0, 8'h00, 0, 4'h0, 0, 0, 1, 32'h0005_1818);

    foreach (tbl[i]) begin
      drive_check(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dwe, tbl[i].dbe, tbl[i].da, tbl[i].dwd);
      chk($sformatf("v%0d_if_gnt", i), bus.if_gnt, tbl[i].e_if);
      chk($sformatf("v%0d_dm_gnt", i), bus.dm_gnt, tbl[i].e_dm);
      chk($sformatf("v%0d_stall_if", i), bus.stall_if, tbl[i].e_stall);
      chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_mem_we", i), bus.mem_we, tbl[i].e_we);
      chk($sformatf("v%0d_mem_be", i), bus.mem_be, tbl[i].e_be);
      chk($sformatf("v%0d_if_rvalid", i), bus.if_rvalid, tbl[i].e_if_rv);
      chk($sformatf("v%0d_dm_rvalid", i), bus.dm_rvalid, tbl[i].e_dm_rv);
      if (tbl[i].e_if_rv) chk($sformatf("v%0d_if_rdata", i), bus.if_rdata, tbl[i].e_if_rd);
      if (tbl[i].e_dm_rv) chk($sformatf("v%0d_dm_rdata", i), bus.dm_rdata, tbl[i].e_dm_rd);
      advance();
    end

    // Reset asserted the cycle after a load grant discards the pending response.
    drive_check(1'b0, 8'h00, 1'b1, 1'b0, 4'hF, 8'h10, 32'h0);
    advance();
    rst_n = 1'b0;
    model_reset();
    drive_check(1'b1, 8'h00, 1'b1, 1'b0, 4'hF, 8'h10, 32'h0);
    chk("rst_mid_dm_rvalid", bus.dm_rvalid, 1'b0);
    chk("rst_mid_if_rvalid", bus.if_rvalid, 1'b0);
    advance();
    drive_check(1'b1, 8'h00, 1'b1, 1'b0, 4'hF, 8'h10, 32'h0);
    advance();
    rst_n = 1'b1;
    // Starvation count restarts from zero after release.
    for (int k = 0; k < 6; k++) begin
      drive_check(1'b1, 8'h0C, 1'b1, 1'b0, 4'hF, 8'h14, 32'h0);
      chk($sformatf("post_rst_if_gnt%0d", k), bus.if_gnt, k == 4);
      if (k == 0) chk("post_rst_dm_rvalid", bus.dm_rvalid, 1'b0);
      advance();
    end

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      drive_check($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, 4'($urandom), 8'($urandom), $urandom);
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
